serial_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one serial transmit path among N_REQ requesters.
- Grants one requester at a time and pulses the datapath load.
- Emits the winner's ID serially as a header, MSB first, then drives DATA_W payload shift cycles.
- Pulses a per-requester done. Sits between the requester-side buffers and the shared shift register / serial output stage.

---
 rtl/serial_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one serial transmit path among N_REQ requesters.
// Each frame is a grant/load cycle, then the winner ID (MSB first), then DATA_W payload shifts, then done.
module serial_tx_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  grant,
    output logic [ID_W-1:0]   sel,
    output logic              ld_shift,
    output logic              shift_en,
    output logic              hdr_bit,
    output logic              hdr_phase,
    output logic              serout_valid,
    output logic [N_REQ-1:0]  done,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = ((DATA_W > ID_W) ? $clog2(DATA_W) : $clog2(ID_W)) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   sel_q, sel_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   pick;
    logic              pick_vld;
    logic [N_REQ-1:0]  sel_oh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            last_q  <= ID_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Walk from the farthest candidate to the nearest so the nearest set bit after last wins.
    always_comb begin
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = last_q + ID_W'(k);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_d   = CNT_W'(ID_W - 1);
                state_d = S_HEADER;
            end
            S_HEADER: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(DATA_W - 1);
                    state_d = S_PAYLOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign sel_oh = {{(N_REQ-1){1'b0}}, 1'b1} << sel_q;

    // Outputs decode registered state only; req never reaches them combinationally.
    always_comb begin
        grant        = '0;
        ld_shift     = 1'b0;
        shift_en     = 1'b0;
        hdr_bit      = 1'b0;
        hdr_phase    = 1'b0;
        serout_valid = 1'b0;
        done         = '0;
        busy         = 1'b0;
        case (state_q)
            S_GRANT: begin
                grant    = sel_oh;
                ld_shift = 1'b1;
                busy     = 1'b1;
            end
            S_HEADER: begin
                grant        = sel_oh;
                hdr_phase    = 1'b1;
                serout_valid = 1'b1;
                busy         = 1'b1;
                for (int i = 0; i < ID_W; i++) begin
                    if (cnt_q == CNT_W'(i)) hdr_bit = sel_q[i];
                end
            end
            S_PAYLOAD: begin
                grant        = sel_oh;
                shift_en     = 1'b1;
                serout_valid = 1'b1;
                busy         = 1'b1;
            end
            S_DONE: begin
                done = sel_oh;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign sel       = sel_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: expected winners are queued when requests are
// driven and each frame is checked cycle by cycle when its grant appears.
module tb_serial_tx_arbiter;

  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int DATA_W = 8;
  // IDLE -> GRANT -> HEADER x ID_W -> PAYLOAD x DATA_W -> DONE -> IDLE
  localparam int PERIOD = 3 + ID_W + DATA_W;

  logic              clk;
  logic              rst;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   sel;
  logic              ld_shift;
  logic              shift_en;
  logic              hdr_bit;
  logic              hdr_phase;
  logic              serout_valid;
  logic [N_REQ-1:0]  done;
  logic              busy;
  logic [2:0]        state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int grant_cyc;
  logic [ID_W-1:0] exp_q[$];

  serial_tx_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel),
    .ld_shift(ld_shift), .shift_en(shift_en), .hdr_bit(hdr_bit),
    .hdr_phase(hdr_phase), .serout_valid(serout_valid), .done(done),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", sel, 0);
    check("rst_valid", serout_valid, 0);
    check("rst_ld", ld_shift, 0);
    check("rst_shift", shift_en, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
  endtask

  // Check one whole frame, starting at (or up to 3 cycles before) its GRANT cycle.
  // req is set to req_hdr in the first HEADER cycle and to req_done in the DONE cycle.
  task automatic run_frame(input logic [N_REQ-1:0] req_hdr, input logic [N_REQ-1:0] req_done);
    logic [ID_W-1:0]  id;
    logic [N_REQ-1:0] oh;
    int sv_cnt;
    for (int k = 0; k < 3 && grant == '0; k++) tick();
    check("grant_seen", (grant != '0), 1);
    if (grant == '0) return;
    if (exp_q.size() == 0) begin
      check("sb_underflow", exp_q.size(), 1);
      return;
    end
    id = exp_q.pop_front();
    oh = N_REQ'(1) << id;
    grant_cyc = cyc;
    sv_cnt = 0;
    check("g_grant", grant, oh);
    check("g_sel", sel, id);
    check("g_ld", ld_shift, 1);
    check("g_busy", busy, 1);
    check("g_valid", serout_valid, 0);
    check("g_done", done, 0);
    for (int h = 0; h < ID_W; h++) begin
      tick();
      if (h == 0) req = req_hdr;
      if (serout_valid) sv_cnt++;
      check("h_phase", hdr_phase, 1);
      check("h_bit", hdr_bit, id[ID_W-1-h]);
      check("h_grant", grant, oh);
      check("h_ld", ld_shift, 0);
      check("h_shift", shift_en, 0);
    end
    for (int p = 0; p < DATA_W; p++) begin
      tick();
      if (serout_valid) sv_cnt++;
      check("p_shift", shift_en, 1);
      check("p_phase", hdr_phase, 0);
      check("p_grant", grant, oh);
      check("p_done", done, 0);
    end
    tick();
    req = req_done;
    check("d_done", done, oh);
    check("d_grant", grant, 0);
    check("d_shift", shift_en, 0);
    check("d_valid", serout_valid, 0);
    check("d_busy", busy, 1);
    check("sv_count", sv_cnt, ID_W + DATA_W);
    tick();
    check("i_busy", busy, 0);
    check("i_done", done, 0);
    check("i_sel_hold", sel, id);
  endtask

  initial begin
    int prev;
    int seen;
    rst = 1'b1;
    req = '0;
    apply_reset();

    // single request from reset goes to requester 0
    req = 4'b0001;
    exp_q.push_back(2'd0);
    tick();
    req = '0;
    run_frame(4'b0000, 4'b0000);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (grant != '0 || done != '0) seen++;
    end
    check("single_no_regrant", seen, 0);

    // all requesting: rotate 0,1,2,3,0 at one frame period
    apply_reset();
    req = 4'b1111;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    tick();
    prev = -1;
    for (int f = 0; f < 5; f++) begin
      run_frame(4'b1111, 4'b1111);
      if (prev >= 0) check("rr_period", grant_cyc - prev, PERIOD);
      prev = grant_cyc;
    end
    req = '0;
    check("rr_queue_empty", exp_q.size(), 0);

    // requester 2 served, requester 0 raises in DONE: 0 wins next
    apply_reset();
    req = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    run_frame(4'b0100, 4'b0101);
    exp_q.push_back(2'd0);
    run_frame(4'b0101, 4'b0000);

    // requester 3: header 1,1
    req = 4'b1000;
    exp_q.push_back(2'd3);
    tick();
    req = '0;
    run_frame(4'b0000, 4'b0000);

    // reset in the 4th payload cycle aborts the frame
    req = 4'b0100;
    tick();
    req = '0;
    check("ab_grant", grant, 4'b0100);
    for (int k = 0; k < ID_W + 4; k++) tick();
    check("ab_in_payload", shift_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_grant0", grant, 0);
    check("ab_shift", shift_en, 0);
    check("ab_done", done, 0);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done != '0 || busy) seen++;
    end
    check("ab_quiet", seen, 0);
    req = 4'b1010;
    exp_q.push_back(2'd1);
    tick();
    run_frame(4'b1010, 4'b0000);

    // pulse that drops during HEADER still completes, no second grant
    req = 4'b0010;
    exp_q.push_back(2'd1);
    tick();
    run_frame(4'b0000, 4'b0000);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (grant != '0) seen++;
    end
    check("drop_no_regrant", seen, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
